// File: rtl/ysyx_041461_wb_rfcsr.sv
// Write-back state block: GPR file with same-cycle write bypass plus machine-mode CSRs and trap/mret redirect.
// Optional cycle/instret counters are built when YSYX_041461_WB_COUNTERS_EN is defined.
module ysyx_041461_wb_rfcsr #(
  parameter int XLEN  = 64,
  parameter int NREAD = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [3:0]            wb_op,
  input  logic [4:0]            wb_rd,
  input  logic [4:0]            wb_rs1,
  input  logic [XLEN-1:0]       wb_exe,
  input  logic [XLEN-1:0]       wb_mem,
  input  logic [XLEN-1:0]       wb_imm,
  input  logic [XLEN-1:0]       wb_pc,
  input  logic [11:0]           wb_csr,
  input  logic [XLEN-1:0]       wb_csr_src,
  input  logic [NREAD*5-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic [11:0]           csr_raddr,
  output logic [XLEN-1:0]       csr_rdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  localparam logic [3:0] OP_EXE     = 4'd1;
  localparam logic [3:0] OP_MEM     = 4'd2;
  localparam logic [3:0] OP_IMM     = 4'd3;
  localparam logic [3:0] OP_SNPC    = 4'd4;
  localparam logic [3:0] OP_CSRRW   = 4'd5;
  localparam logic [3:0] OP_CSRRS   = 4'd6;
  localparam logic [3:0] OP_CSRRC   = 4'd7;
  localparam logic [3:0] OP_ECALL   = 4'd8;
  localparam logic [3:0] OP_EBREAK  = 4'd9;
  localparam logic [3:0] OP_ILLEGAL = 4'd10;
  localparam logic [3:0] OP_MRET    = 4'd11;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  logic [XLEN-1:0] gpr_r [0:31];
  logic            mie_r;
  logic            mpie_r;
  logic [XLEN-1:0] mtvec_r;
  logic [XLEN-1:0] mscratch_r;
  logic [XLEN-1:0] mepc_r;
  logic [XLEN-1:0] mcause_r;
`ifdef YSYX_041461_WB_COUNTERS_EN
  logic [XLEN-1:0] mcycle_r;
  logic [XLEN-1:0] minstret_r;
`endif
  logic            redirect_valid_r;
  logic [XLEN-1:0] redirect_pc_r;

  logic [XLEN-1:0]       mstatus_s;
  logic                  dec_gpr_s;
  logic                  dec_csr_s;
  logic                  dec_trap_s;
  logic                  dec_mret_s;
  logic [XLEN-1:0]       dec_cause_s;
  logic                  gpr_we_s;
  logic                  csr_op_s;
  logic                  trap_s;
  logic                  mret_s;
  logic                  retire_s;
  logic [XLEN:0]         csr_wb_lookup_s;
  logic [XLEN:0]         csr_ex_lookup_s;
  logic                  csr_hit_s;
  logic [XLEN-1:0]       csr_old_s;
  logic [XLEN-1:0]       csr_new_s;
  logic                  csr_we_s;
  logic [XLEN-1:0]       gpr_wdata_s;
  logic [NREAD*XLEN-1:0] rd_data_s;

  // Returns {hit, value} for a CSR address using the current architectural state.
  function automatic logic [XLEN:0] csr_lookup(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS:  csr_lookup = {1'b1, mstatus_s};
      CSR_MTVEC:    csr_lookup = {1'b1, mtvec_r};
      CSR_MSCRATCH: csr_lookup = {1'b1, mscratch_r};
      CSR_MEPC:     csr_lookup = {1'b1, mepc_r};
      CSR_MCAUSE:   csr_lookup = {1'b1, mcause_r};
`ifdef YSYX_041461_WB_COUNTERS_EN
      CSR_MCYCLE:   csr_lookup = {1'b1, mcycle_r};
      CSR_MINSTRET: csr_lookup = {1'b1, minstret_r};
`endif
      default:      csr_lookup = {1'b0, {XLEN{1'b0}}};
    endcase
  endfunction

  // mstatus view: only MIE/MPIE are state, MPP is hardwired to machine mode.
  always_comb begin
    mstatus_s        = '0;
    mstatus_s[12:11] = 2'b11;
    mstatus_s[7]     = mpie_r;
    mstatus_s[3]     = mie_r;
  end

  // Operation decode; 0 and 12-15 decode to nothing.
  always_comb begin
    dec_gpr_s   = 1'b0;
    dec_csr_s   = 1'b0;
    dec_trap_s  = 1'b0;
    dec_mret_s  = 1'b0;
    dec_cause_s = '0;
    case (wb_op)
      OP_EXE, OP_MEM, OP_IMM, OP_SNPC: dec_gpr_s = 1'b1;
      OP_CSRRW, OP_CSRRS, OP_CSRRC: begin
        dec_gpr_s = 1'b1;
        dec_csr_s = 1'b1;
      end
      OP_ECALL: begin
        dec_trap_s  = 1'b1;
        dec_cause_s = XLEN'(11);
      end
      OP_EBREAK: begin
        dec_trap_s  = 1'b1;
        dec_cause_s = XLEN'(3);
      end
      OP_ILLEGAL: begin
        dec_trap_s  = 1'b1;
        dec_cause_s = XLEN'(2);
      end
      OP_MRET: dec_mret_s = 1'b1;
      default: dec_gpr_s = 1'b0;
    endcase
  end

  assign gpr_we_s = wb_valid & dec_gpr_s;
  assign csr_op_s = wb_valid & dec_csr_s;
  assign trap_s   = wb_valid & dec_trap_s;
  assign mret_s   = wb_valid & dec_mret_s;
  assign retire_s = gpr_we_s | trap_s | mret_s;

  assign csr_wb_lookup_s = csr_lookup(wb_csr);
  assign csr_ex_lookup_s = csr_lookup(csr_raddr);
  assign csr_hit_s       = csr_wb_lookup_s[XLEN];
  assign csr_old_s       = csr_wb_lookup_s[XLEN-1:0];

  // Read-modify-write value; RS/RC with a zero rs1 field leave the CSR alone.
  always_comb begin
    case (wb_op)
      OP_CSRRW: csr_new_s = wb_csr_src;
      OP_CSRRS: csr_new_s = csr_old_s | wb_csr_src;
      OP_CSRRC: csr_new_s = csr_old_s & ~wb_csr_src;
      default:  csr_new_s = csr_old_s;
    endcase
    csr_we_s = csr_op_s & csr_hit_s & ((wb_op == OP_CSRRW) | (wb_rs1 != 5'd0));
  end

  // GPR write-data source select.
  always_comb begin
    case (wb_op)
      OP_EXE:                       gpr_wdata_s = wb_exe;
      OP_MEM:                       gpr_wdata_s = wb_mem;
      OP_IMM:                       gpr_wdata_s = wb_imm;
      OP_SNPC:                      gpr_wdata_s = wb_pc + XLEN'(4);
      OP_CSRRW, OP_CSRRS, OP_CSRRC: gpr_wdata_s = csr_old_s;
      default:                      gpr_wdata_s = '0;
    endcase
  end

  // Read ports with same-cycle bypass of the retiring write.
  always_comb begin
    rd_data_s = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (rd_addr[5*k +: 5] == 5'd0) begin
        rd_data_s[k*XLEN +: XLEN] = '0;
      end else if (gpr_we_s && (wb_rd == rd_addr[5*k +: 5])) begin
        rd_data_s[k*XLEN +: XLEN] = gpr_wdata_s;
      end else begin
        rd_data_s[k*XLEN +: XLEN] = gpr_r[rd_addr[5*k +: 5]];
      end
    end
  end

  // GPR array; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= '0;
      end
    end else if (gpr_we_s && (wb_rd != 5'd0)) begin
      gpr_r[wb_rd] <= gpr_wdata_s;
    end
  end

  // Machine CSRs: trap entry, mret, then explicit software writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_r      <= 1'b0;
      mpie_r     <= 1'b0;
      mtvec_r    <= '0;
      mscratch_r <= '0;
      mepc_r     <= '0;
      mcause_r   <= '0;
    end else if (trap_s) begin
      mepc_r   <= {wb_pc[XLEN-1:2], 2'b00};
      mcause_r <= dec_cause_s;
      mpie_r   <= mie_r;
      mie_r    <= 1'b0;
    end else if (mret_s) begin
      mie_r  <= mpie_r;
      mpie_r <= 1'b1;
    end else if (csr_we_s) begin
      case (wb_csr)
        CSR_MSTATUS: begin
          mie_r  <= csr_new_s[3];
          mpie_r <= csr_new_s[7];
        end
        CSR_MTVEC:    mtvec_r    <= {csr_new_s[XLEN-1:2], 2'b00};
        CSR_MSCRATCH: mscratch_r <= csr_new_s;
        CSR_MEPC:     mepc_r     <= {csr_new_s[XLEN-1:2], 2'b00};
        CSR_MCAUSE:   mcause_r   <= csr_new_s;
        default:      mcause_r   <= mcause_r;
      endcase
    end
  end

`ifdef YSYX_041461_WB_COUNTERS_EN
  // Free-running counters; a software write in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r   <= '0;
      minstret_r <= '0;
    end else begin
      if (csr_we_s && (wb_csr == CSR_MCYCLE)) begin
        mcycle_r <= csr_new_s;
      end else begin
        mcycle_r <= mcycle_r + XLEN'(1);
      end
      if (csr_we_s && (wb_csr == CSR_MINSTRET)) begin
        minstret_r <= csr_new_s;
      end else if (retire_s) begin
        minstret_r <= minstret_r + XLEN'(1);
      end
    end
  end
`endif

  // Redirect pulse; the target uses the pre-update mtvec/mepc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= '0;
    end else begin
      redirect_valid_r <= trap_s | mret_s;
      if (trap_s) begin
        redirect_pc_r <= mtvec_r;
      end else if (mret_s) begin
        redirect_pc_r <= mepc_r;
      end
    end
  end

  assign rd_data        = rd_data_s;
  assign csr_rdata      = csr_ex_lookup_s[XLEN-1:0];
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_ysyx_041461_wb_rfcsr.sv
// Scoreboard bench for ysyx_041461_wb_rfcsr: expectations are queued when stimulus is driven and popped as outputs are sampled.
module tb_ysyx_041461_wb_rfcsr;
  localparam int XLEN  = 64;
  localparam int NREAD = 5;

  logic                  clk;
  logic                  rst_n;
  logic                  wb_valid;
  logic [3:0]            wb_op;
  logic [4:0]            wb_rd;
  logic [4:0]            wb_rs1;
  logic [XLEN-1:0]       wb_exe;
  logic [XLEN-1:0]       wb_mem;
  logic [XLEN-1:0]       wb_imm;
  logic [XLEN-1:0]       wb_pc;
  logic [11:0]           wb_csr;
  logic [XLEN-1:0]       wb_csr_src;
  logic [NREAD*5-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [11:0]           csr_raddr;
  logic [XLEN-1:0]       csr_rdata;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;

  ysyx_041461_wb_rfcsr #(.XLEN(XLEN), .NREAD(NREAD)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_op(wb_op), .wb_rd(wb_rd),
    .wb_rs1(wb_rs1), .wb_exe(wb_exe), .wb_mem(wb_mem), .wb_imm(wb_imm), .wb_pc(wb_pc),
    .wb_csr(wb_csr), .wb_csr_src(wb_csr_src), .rd_addr(rd_addr), .rd_data(rd_data),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 64'(sb_q.size()), 64'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [63:0] port_data(input int k);
    return rd_data[k*XLEN +: XLEN];
  endfunction

  task automatic set_port(input int k, input logic [4:0] a);
    rd_addr[k*5 +: 5] = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_op = 4'd0; wb_rd = 5'd0; wb_rs1 = 5'd0;
    wb_exe = '0; wb_mem = '0; wb_imm = '0; wb_pc = '0; wb_csr = 12'h000; wb_csr_src = '0;
  endtask

  // Sources are offset so a wrong mux selection shows up.
  task automatic drive(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [11:0] csr, input logic [63:0] src,
                       input logic [63:0] val, input logic [63:0] pc);
    wb_valid = 1'b1; wb_op = op; wb_rd = rd; wb_rs1 = rs1; wb_csr = csr; wb_csr_src = src;
    wb_exe = val; wb_mem = val + 64'd1; wb_imm = val + 64'd2; wb_pc = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr   = '0;
    csr_raddr = 12'h300;
    push_exp("rst_mstatus", 64'h1800);
    push_exp("rst_redir_valid", 64'd0);
    push_exp("rst_redir_pc", 64'd0);
    #2;
    observe(csr_rdata); observe(64'(redirect_valid)); observe(redirect_pc);
    tick(); tick();
    rst_n = 1'b1;

    // GPR write with bypass, and x0 protection
    drive(4'd1, 5'd5, 5'd0, 12'h000, 64'd0, 64'h1234, 64'd0);
    set_port(2, 5'd5); set_port(0, 5'd0);
    push_exp("byp_x5", 64'h1234); push_exp("x0_port", 64'd0);
    #1; observe(port_data(2)); observe(port_data(0));
    tick(); idle();
    push_exp("arr_x5", 64'h1234);
    #1; observe(port_data(2));
    drive(4'd1, 5'd0, 5'd0, 12'h000, 64'd0, 64'hDEAD, 64'd0);
    set_port(1, 5'd0);
    push_exp("byp_x0", 64'd0);
    #1; observe(port_data(1));
    tick(); idle();
    push_exp("arr_x0", 64'd0);
    #1; observe(port_data(1));

    // MEM / IMM / SNPC sources, SNPC wraps
    drive(4'd2, 5'd13, 5'd0, 12'h000, 64'd0, 64'hABC0, 64'd0); tick();
    drive(4'd3, 5'd14, 5'd0, 12'h000, 64'd0, 64'h100, 64'd0); tick();
    drive(4'd4, 5'd15, 5'd0, 12'h000, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE); tick();
    idle();
    set_port(0, 5'd13); set_port(1, 5'd14); set_port(2, 5'd15);
    push_exp("arr_mem", 64'hABC1); push_exp("arr_imm", 64'h102); push_exp("arr_snpc", 64'h2);
    #1; observe(port_data(0)); observe(port_data(1)); observe(port_data(2));

    // CSRRW mtvec: rd gets old value, low bits masked
    drive(4'd1, 5'd6, 5'd0, 12'h000, 64'd0, 64'h77, 64'd0); tick();
    drive(4'd5, 5'd6, 5'd1, 12'h305, 64'h8000_0003, 64'd0, 64'd0);
    set_port(3, 5'd6);
    push_exp("byp_csrrw_old", 64'd0);
    #1; observe(port_data(3));
    tick(); idle(); csr_raddr = 12'h305;
    push_exp("mtvec", 64'h8000_0000);
    #1; observe(csr_rdata);

    // CSRRS mstatus sets MIE
    drive(4'd6, 5'd7, 5'd1, 12'h300, 64'h8, 64'd0, 64'd0);
    set_port(3, 5'd7);
    push_exp("byp_csrrs_old", 64'h1800);
    #1; observe(port_data(3));
    tick(); idle(); csr_raddr = 12'h300;
    push_exp("mstatus_mie", 64'h1808);
    #1; observe(csr_rdata);

    // CSRRC with rs1=0 does not write, then a real clear
    drive(4'd5, 5'd0, 5'd1, 12'h340, 64'hFF, 64'd0, 64'd0); tick();
    drive(4'd7, 5'd8, 5'd0, 12'h340, 64'hFF, 64'd0, 64'd0);
    set_port(4, 5'd8);
    push_exp("byp_csrrc_rs0", 64'hFF);
    #1; observe(port_data(4));
    tick(); idle(); csr_raddr = 12'h340;
    push_exp("mscratch_kept", 64'hFF); push_exp("arr_x8", 64'hFF);
    #1; observe(csr_rdata); observe(port_data(4));
    drive(4'd7, 5'd9, 5'd3, 12'h340, 64'h0F, 64'd0, 64'd0); tick(); idle();
    push_exp("mscratch_clr", 64'hF0);
    #1; observe(csr_rdata);

    // unknown CSR: rd written 0, reads 0
    drive(4'd1, 5'd10, 5'd0, 12'h000, 64'd0, 64'hAA, 64'd0); tick();
    drive(4'd5, 5'd10, 5'd1, 12'h7C0, 64'h55, 64'd0, 64'd0);
    set_port(0, 5'd10);
    push_exp("byp_unknown_csr", 64'd0);
    #1; observe(port_data(0));
    tick(); idle(); csr_raddr = 12'h7C0;
    push_exp("unknown_csr_read", 64'd0);
    #1; observe(csr_rdata);

    // ECALL with wb_valid low does nothing
    drive(4'd8, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'h4000); wb_valid = 1'b0;
    tick(); idle(); csr_raddr = 12'h342;
    push_exp("novalid_redir", 64'd0); push_exp("novalid_mcause", 64'd0);
    #1; observe(64'(redirect_valid)); observe(csr_rdata);

    // ECALL
    drive(4'd8, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'h8000_0010);
    tick(); idle(); csr_raddr = 12'h341;
    push_exp("ecall_redir_valid", 64'd1); push_exp("ecall_redir_pc", 64'h8000_0000);
    push_exp("ecall_mepc", 64'h8000_0010);
    #1; observe(64'(redirect_valid)); observe(redirect_pc); observe(csr_rdata);
    tick(); csr_raddr = 12'h342;
    push_exp("ecall_redir_drop", 64'd0); push_exp("ecall_mcause", 64'd11);
    #1; observe(64'(redirect_valid)); observe(csr_rdata);
    tick(); csr_raddr = 12'h300;
    push_exp("ecall_mstatus", 64'h1880); push_exp("redir_pc_held", 64'h8000_0000);
    #1; observe(csr_rdata); observe(redirect_pc);

    // MRET
    drive(4'd11, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'd0);
    tick(); idle();
    push_exp("mret_redir_valid", 64'd1); push_exp("mret_redir_pc", 64'h8000_0010);
    push_exp("mret_mstatus", 64'h1888);
    #1; observe(64'(redirect_valid)); observe(redirect_pc); observe(csr_rdata);
    tick();
    push_exp("mret_redir_drop", 64'd0);
    #1; observe(64'(redirect_valid));

    // EBREAK / ILLEGAL causes and nested MIE/MPIE
    drive(4'd9, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'h200);
    tick(); idle(); csr_raddr = 12'h342;
    push_exp("ebreak_redir_pc", 64'h8000_0000); push_exp("ebreak_mcause", 64'd3);
    #1; observe(redirect_pc); observe(csr_rdata);
    drive(4'd10, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'h300);
    tick(); idle();
    push_exp("illegal_mcause", 64'd2);
    #1; observe(csr_rdata);
    csr_raddr = 12'h300;
    push_exp("illegal_mstatus", 64'h1800);
    #1; observe(csr_rdata);

    // asynchronous reset while a redirect is pending
    drive(4'd8, 5'd0, 5'd0, 12'h000, 64'd0, 64'd0, 64'h500);
    tick(); idle(); csr_raddr = 12'h305; set_port(2, 5'd5);
    push_exp("pre_rst_redir", 64'd1);
    #1; observe(64'(redirect_valid));
    rst_n = 1'b0;
    push_exp("arst_redir_valid", 64'd0); push_exp("arst_redir_pc", 64'd0);
    push_exp("arst_mtvec", 64'd0); push_exp("arst_x5", 64'd0);
    #1; observe(64'(redirect_valid)); observe(redirect_pc); observe(csr_rdata); observe(port_data(2));
    tick(); tick();
    rst_n = 1'b1;

    // counters: 10 idle cycles then 3 retiring EXE
    for (int i = 0; i < 10; i++) begin
      idle(); tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'd1, 5'd16, 5'd0, 12'h000, 64'd0, 64'(i), 64'd0); tick();
    end
`ifdef YSYX_041461_WB_COUNTERS_EN
    drive(4'd6, 5'd11, 5'd0, 12'hB00, 64'hFFFF, 64'd0, 64'd0);
    set_port(0, 5'd11); csr_raddr = 12'hB02;
    push_exp("mcycle_13", 64'd13); push_exp("minstret_3", 64'd3);
    #1; observe(port_data(0)); observe(csr_rdata);
    tick();
    drive(4'd5, 5'd0, 5'd1, 12'hB00, 64'd0, 64'd0, 64'd0);
    tick(); idle(); csr_raddr = 12'hB00;
    push_exp("mcycle_write_wins", 64'd0);
    #1; observe(csr_rdata);
    tick(); csr_raddr = 12'hB02;
    push_exp("minstret_5", 64'd5);
    #1; observe(csr_rdata);
`else
    drive(4'd1, 5'd11, 5'd0, 12'h000, 64'd0, 64'h99, 64'd0); tick();
    drive(4'd5, 5'd11, 5'd1, 12'hB00, 64'd5, 64'd0, 64'd0);
    set_port(0, 5'd11);
    push_exp("byp_mcycle_absent", 64'd0);
    #1; observe(port_data(0));
    tick(); idle(); csr_raddr = 12'hB00;
    push_exp("mcycle_absent", 64'd0);
    #1; observe(csr_rdata);
    csr_raddr = 12'hB02;
    push_exp("minstret_absent", 64'd0);
    #1; observe(csr_rdata);
`endif

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
